// File: rtl/conv2_sched.sv
// conv2_sched: frame scheduler for the conv2 stage. Counts raster pixels, flags complete
// KxK windows, tags calc results with output-map coordinates and guards the drain phase.
module conv2_sched #(
    parameter int IMG_W    = 12,
    parameter int IMG_H    = 12,
    parameter int K        = 5,
    parameter int CALC_LAT = 8,
    parameter int TMO      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       win_valid,
    input  logic       calc_valid,
    output logic       out_valid,
    output logic [3:0] out_x,
    output logic [3:0] out_y,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int TOTAL = OUT_W * OUT_H;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int NW = $clog2(TOTAL + 1);
    localparam int XW = $clog2(OUT_W + 1);
    localparam int YW = $clog2(OUT_H + 1);
    localparam int TW = $clog2(TMO + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [NW-1:0] RES_TOT  = NW'(TOTAL);
    localparam logic [NW-1:0] RES_LAST = NW'(TOTAL - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(OUT_W - 1);
    localparam logic [TW-1:0] WD_LAST  = TW'(TMO - 1);

    // The watchdog must outlast one calc pipeline flight or a healthy drain would time out.
    if (TMO <= CALC_LAT) begin : g_tmo_chk
        $error("conv2_sched: TMO must exceed CALC_LAT");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [NW-1:0] win_cnt_q;
    logic [NW-1:0] res_cnt_q;
    logic [XW-1:0] res_x_q;
    logic [YW-1:0] res_y_q;
    logic [TW-1:0] wdog_q;

    logic          in_ready_q;
    logic          win_valid_q;
    logic          out_valid_q;
    logic [3:0]    out_x_q;
    logic [3:0]    out_y_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    err_q;

    logic          pix_acc;
    logic          pix_last;
    logic          win_hit;
    logic          live;
    logic          res_acc;
    logic          res_bad;
    logic [NW-1:0] res_cnt_d;

    always_comb begin
        pix_acc   = in_valid && in_ready_q;
        pix_last  = pix_acc && (row_q == ROW_LAST) && (col_q == COL_LAST);
        win_hit   = pix_acc && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
        live      = (state_q == S_FILL) || (state_q == S_DRAIN);
        // Results beyond the frame total are errors, never extra outputs.
        res_acc   = calc_valid && live && (res_cnt_q != RES_TOT);
        res_bad   = calc_valid && !res_acc;
        res_cnt_d = res_cnt_q + {{(NW-1){1'b0}}, res_acc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_cnt_q   <= '0;
            res_cnt_q   <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            wdog_q      <= '0;
            in_ready_q  <= 1'b0;
            win_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            win_valid_q <= win_hit;
            out_valid_q <= res_acc;
            done_q      <= 1'b0;
            res_cnt_q   <= res_cnt_d;

            if (res_acc) begin
                out_x_q    <= 4'(res_x_q);
                out_y_q    <= 4'(res_y_q);
                out_last_q <= (res_cnt_q == RES_LAST);
                if (res_x_q == X_LAST) begin
                    res_x_q <= '0;
                    res_y_q <= res_y_q + 1'b1;
                end else begin
                    res_x_q <= res_x_q + 1'b1;
                end
            end else begin
                out_x_q    <= '0;
                out_y_q    <= '0;
                out_last_q <= 1'b0;
            end

            if (res_bad) begin
                err_q[0] <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FILL;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                        win_cnt_q  <= '0;
                        res_cnt_q  <= '0;
                        res_x_q    <= '0;
                        res_y_q    <= '0;
                        wdog_q     <= '0;
                        err_q      <= '0;
                    end
                end
                S_FILL: begin
                    if (pix_acc) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    if (win_hit) begin
                        win_cnt_q <= win_cnt_q + 1'b1;
                    end
                    if (pix_last) begin
                        state_q    <= S_DRAIN;
                        in_ready_q <= 1'b0;
                        wdog_q     <= '0;
                    end
                end
                S_DRAIN: begin
                    if (res_cnt_d == RES_TOT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (calc_valid) begin
                        wdog_q <= '0;
                    end else if (wdog_q == WD_LAST) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        err_q[1] <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign win_valid = win_valid_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: randomized pixel gaps, calc loopback of win_valid, per-cycle
// comparison against a count-based frame model plus literal per-frame expectations.
module tb_conv2_sched;

    localparam int IMG_W    = 12;
    localparam int IMG_H    = 12;
    localparam int K        = 5;
    localparam int CALC_LAT = 8;
    localparam int TMO      = 16;
    localparam int OUT_W    = IMG_W - K + 1;
    localparam int OUT_H    = IMG_H - K + 1;
    localparam int TOTAL    = OUT_W * OUT_H;
    localparam int NPIX     = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       win_valid;
    logic       calc_valid;
    logic       out_valid;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [1:0] err;

    conv2_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CALC_LAT(CALC_LAT), .TMO(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .win_valid(win_valid), .calc_valid(calc_valid), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int iv_mode = 0;
    bit drop_last = 0;
    bit inject = 0;
    int calc_n = 0;
    int last_rst_cyc = -1;
    bit win_hist [0:8191];

    int n_win, n_ov, n_done, n_pix, n_last;
    int first_win_cyc, err1_cyc, ov_last_cyc;
    logic [7:0] last_xy;
    logic [7:0] coord_q[$];
    logic [7:0] ref_q[$];

    // frame model: plain counts of pixels and results
    bit m_fill = 0, m_drain = 0, m_donep = 0;
    int m_pix = 0, m_res = 0, m_quiet = 0;
    logic [1:0] m_err = '0;
    logic e_ready = 0, e_win = 0, e_ov = 0, e_last = 0, e_busy = 0, e_done = 0, e_rst = 1;
    logic [3:0] e_x = '0, e_y = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit was_fill, was_drain, was_done, was_idle;
        check("cycle outputs", {24'd0, in_ready, win_valid, out_valid, out_last, busy, done, err},
              {24'd0, e_ready, e_win, e_ov, e_last, e_busy, e_done, m_err});
        if (e_ov || e_rst)
            check("out_xy", {24'd0, out_x, out_y}, {24'd0, e_x, e_y});

        if (!rst_n) begin
            m_fill = 0; m_drain = 0; m_donep = 0;
            m_pix = 0; m_res = 0; m_quiet = 0; m_err = '0;
            e_win = 0; e_ov = 0; e_last = 0; e_done = 0; e_x = '0; e_y = '0;
            e_rst = 1;
        end else begin
            was_fill = m_fill; was_drain = m_drain; was_done = m_donep;
            was_idle = !(m_fill || m_drain || m_donep);
            e_rst = 0; e_win = 0; e_ov = 0; e_last = 0; e_done = 0; e_x = '0; e_y = '0;
            if (was_fill && in_valid) begin
                e_win = (m_pix / IMG_W >= K - 1) && (m_pix % IMG_W >= K - 1);
                m_pix++;
                if (m_pix == NPIX) begin
                    m_fill = 0; m_drain = 1; m_quiet = 0;
                end
            end
            if (calc_valid) begin
                if ((was_fill || was_drain) && m_res < TOTAL) begin
                    e_ov = 1;
                    e_x = 4'(m_res % OUT_W);
                    e_y = 4'(m_res / OUT_W);
                    e_last = (m_res == TOTAL - 1);
                    m_res++;
                end else begin
                    m_err[0] = 1'b1;
                end
            end
            if (was_drain) begin
                if (m_res == TOTAL) begin
                    m_drain = 0; m_donep = 1; e_done = 1;
                end else if (calc_valid) begin
                    m_quiet = 0;
                end else if (m_quiet == TMO - 1) begin
                    m_err[1] = 1'b1; m_drain = 0; m_donep = 1; e_done = 1;
                end else begin
                    m_quiet++;
                end
            end
            if (was_done) m_donep = 0;
            if (was_idle && start) begin
                m_fill = 1; m_pix = 0; m_res = 0; m_err = '0;
            end
        end
        e_ready = m_fill;
        e_busy  = m_fill || m_drain || m_donep;

        if (cyc < 8192) win_hist[cyc] = (win_valid === 1'b1);
        if (in_valid && in_ready) n_pix++;
        if (win_valid) begin
            n_win++;
            if (first_win_cyc < 0) first_win_cyc = cyc;
        end
        if (out_valid) begin
            n_ov++;
            coord_q.push_back({out_x, out_y});
            ov_last_cyc = cyc;
        end
        if (out_last) begin
            n_last++;
            last_xy = {out_x, out_y};
        end
        if (done) n_done++;
        if (err[1] && err1_cyc < 0) err1_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        case (iv_mode)
            0: in_valid = 1'b0;
            1: in_valid = 1'b1;
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        calc_valid = 1'b0;
        if (cyc >= CALC_LAT && cyc - CALC_LAT > last_rst_cyc && cyc - CALC_LAT < 8192 &&
            win_hist[cyc - CALC_LAT]) begin
            if (!(drop_last && calc_n == TOTAL - 1)) calc_valid = 1'b1;
            calc_n++;
        end
        if (inject) begin
            calc_valid = 1'b1;
            inject = 0;
        end
    endtask

    task automatic clr_stats();
        n_win = 0; n_ov = 0; n_done = 0; n_pix = 0; n_last = 0;
        first_win_cyc = -1; err1_cyc = -1; ov_last_cyc = -1;
        last_xy = '0; calc_n = 0;
        coord_q.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && n_done == 0; i++) tick();
        check("frame reached done", {31'd0, n_done > 0}, 32'd1);
        repeat (3) tick();
        iv_mode = 0;
    endtask

    task automatic run_frame(input int mode, input bit drop, input bit mid_start, output int s);
        clr_stats();
        drop_last = drop;
        iv_mode = mode;
        tick();
        start = 1'b1;
        s = cyc;
        for (int i = 0; i < 2000 && n_done == 0; i++) begin
            tick();
            if (mid_start && cyc == s + 30) start = 1'b1;
        end
        check("frame reached done", {31'd0, n_done > 0}, 32'd1);
        repeat (3) tick();
        iv_mode = 0;
        drop_last = 0;
    endtask

    task automatic check_raster(input string name);
        int bad = 0;
        for (int i = 0; i < coord_q.size() && i < TOTAL; i++)
            if (coord_q[i] !== {4'(i % OUT_W), 4'(i / OUT_W)}) bad++;
        check({name, " size"}, coord_q.size(), TOTAL);
        check({name, " order"}, bad, 0);
    endtask

    initial begin
        int s;
        int bad;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; calc_valid = 1'b0;
        clr_stats();
        tick(); tick();
        #2 check("reset outputs", {23'd0, in_ready, win_valid, out_valid, out_x, out_y, out_last, busy, done, err}, 32'd0);
        tick();
        rst_n = 1'b1;

        // gap-free frame
        run_frame(1, 0, 0, s);
        check("f1 win count", n_win, TOTAL);
        check("f1 first win cycle", first_win_cyc, s + 54);
        check("f1 result count", n_ov, 64);
        check("f1 out_last count", n_last, 1);
        check("f1 last coord", {24'd0, last_xy}, 32'h77);
        check("f1 done pulses", n_done, 1);
        check("f1 err", {30'd0, err}, 32'd0);
        check_raster("f1 raster");
        ref_q = coord_q;

        // 50% random pixel gaps
        run_frame(2, 0, 0, s);
        check("f2 win count", n_win, 64);
        check("f2 done pulses", n_done, 1);
        check("f2 err", {30'd0, err}, 32'd0);
        bad = 0;
        for (int i = 0; i < ref_q.size(); i++)
            if (i >= coord_q.size() || coord_q[i] !== ref_q[i]) bad++;
        check("f2 coords vs gap-free", bad, 0);
        check_raster("f2 raster");

        // stray calc result while idle
        clr_stats();
        inject = 1;
        tick(); tick(); tick();
        check("idle inject err", {30'd0, err}, 32'd1);
        check("idle inject out_valid", n_ov, 0);

        // last result dropped: drain watchdog
        run_frame(1, 1, 0, s);
        check("f3 result count", n_ov, 63);
        check("f3 err", {30'd0, err}, 32'd2);
        check("f3 timeout delay", err1_cyc - ov_last_cyc, TMO);
        check("f3 done pulses", n_done, 1);
        check("f3 busy after", {31'd0, busy}, 32'd0);

        // reset mid-frame, then start on the first released cycle
        clr_stats();
        iv_mode = 1;
        tick();
        start = 1'b1;
        for (int i = 0; i < 500 && n_pix < 70; i++) tick();
        check("f4 pixels before reset", n_pix, 70);
        iv_mode = 0;
        rst_n = 1'b0;
        last_rst_cyc = cyc;
        tick();
        #2 check("f4 outputs in reset", {23'd0, in_ready, win_valid, out_valid, out_x, out_y, out_last, busy, done, err}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        clr_stats();
        iv_mode = 1;
        start = 1'b1;
        s = cyc;
        wait_done();
        check("f4 result count", n_ov, 64);
        check("f4 done pulses", n_done, 1);
        check("f4 err", {30'd0, err}, 32'd0);
        check("f4 first win cycle", first_win_cyc, s + 54);

        // start pulsed during FILL is ignored
        run_frame(1, 0, 1, s);
        check("f5 result count", n_ov, 64);
        check("f5 first win cycle", first_win_cyc, s + 54);
        check("f5 done pulses", n_done, 1);
        check("f5 err", {30'd0, err}, 32'd0);
        check_raster("f5 raster");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
REQ-001 Parameter IMG_W, default 12: input feature-map width in pixels.
REQ-002 Parameter IMG_H, default 12: input feature-map height in pixels.
REQ-003 Parameter K, default 5: convolution kernel size.
REQ-004 Parameter CALC_LAT, default 8: cycles from window-valid to result-valid in the conv2 calc datapath.
REQ-005 Parameter TMO, default 16: drain watchdog limit in cycles; TMO SHALL be greater than CALC_LAT.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle request to process one 3-channel frame.
REQ-009 in_valid  in  1  3-channel pixel available from the line buffers.
REQ-010 in_ready  out  1  scheduler accepts a pixel this cycle.
REQ-011 win_valid  out  1  a complete 5x5x3 window is present; drives the calc valid input.
REQ-012 calc_valid  in  1  result valid from the calc datapath.
REQ-013 out_valid  out  1  registered copy of an accepted calc_valid.
REQ-014 out_x, out_y  out  4 each  output-map coordinate of the current out_valid result.
REQ-015 out_last  out  1  high with out_valid for the final result of the frame.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at frame end.
REQ-018 err  out  2  sticky flags: bit0 = unexpected calc_valid, bit1 = drain timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, FILL, DRAIN and DONE.
REQ-020 IDLE: in_ready=0; start=1 -> FILL, clearing col, row, pixel, window and result counters and err.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 FILL: in_ready=1; a pixel is accepted when in_valid and in_ready are both high.
REQ-023 On each accepted pixel, col SHALL increment; at col=IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-024 win_valid SHALL be asserted for exactly one cycle, on the cycle after an accepted pixel with row>=K-1 and col>=K-1; it SHALL be 0 otherwise.
REQ-025 The window counter SHALL increment with each win_valid; expected total = (IMG_W-K+1)*(IMG_H-K+1), which is 64 at default parameters.
REQ-026 The accepted pixel with row=IMG_H-1 and col=IMG_W-1 SHALL move FILL -> DRAIN on the next edge, and in_ready SHALL be 0 from that edge onward.
REQ-027 A calc_valid in FILL or DRAIN SHALL produce out_valid one cycle later, with out_x, out_y taken from the result counter (x = count mod OUT_W, y = count div OUT_W), after which the result counter increments.
REQ-028 out_last SHALL be 1 when result count = total-1.
REQ-029 DRAIN -> DONE when result count reaches the total.
REQ-030 A DRAIN watchdog SHALL reload on each calc_valid; if it reaches TMO, err[1] SHALL be set and the FSM SHALL go to DONE.
REQ-031 A calc_valid in IDLE or DONE, or after the total is reached, SHALL set err[0] and produce no out_valid.
REQ-032 DONE: done=1 for one cycle, then IDLE unconditionally; err SHALL hold until the next accepted start.
REQ-033 A calc_valid on the same edge as the last pixel SHALL be counted normally, with no lost or duplicate result.
REQ-034 All counters SHALL be sized for the parameters, with no wrap within one frame.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force IDLE, all counters 0, and every output 0 (in_ready, win_valid, out_valid, out_x, out_y, out_last, busy, done, err), including mid-frame.
REQ-036 After reset the block SHALL accept start on the first cycle with rst_n=1.

Verification
REQ-037 start, then 144 pixels with in_valid held high, calc_valid modeled as win_valid delayed 8 cycles -> 64 win_valid pulses, first on the cycle after pixel 52 (row 4, col 4), 64 out_valid, out_last with (7,7), done once, err=0.
REQ-038 Random in_valid gaps (50% duty) -> win_valid count 64, coordinate sequence (0,0)..(7,7) in raster order, identical to the gap-free run.
REQ-039 Model drops the last result -> err[1] set TMO cycles after result 63, done pulse, then IDLE.
REQ-040 calc_valid injected in IDLE -> err[0]=1, out_valid stays 0.
REQ-041 rst_n=0 after 70 pixels, then a new start -> all outputs 0 during reset, next frame yields exactly 64 results.
REQ-042 start pulsed during FILL -> no counter clears, frame completes normally.
